// File: rtl/riscv_nn_prefetch_ctrl.sv
// rtl/riscv_nn_prefetch_ctrl.sv - IF-stage instruction prefetch controller
// Single-outstanding fetcher feeding the fetch FIFO, with branch abort and hwlp redirect.
module riscv_nn_prefetch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        hwlp_branch_i,
  input  logic [31:0] hwlp_target_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        fifo_clear_o,
  output logic        fifo_valid_o,
  output logic [31:0] fifo_addr_o,
  output logic [31:0] fifo_rdata_o,
  input  logic        fifo_ready_i,
  output logic        fifo_replace2_o,
  output logic        fifo_is_hwlp_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID, WAIT_ABORTED} state_t;

  state_t      state, state_next;
  logic [31:0] fetch_addr_q, req_addr_q, tgt_q, hwlp_q;
  logic        tgt_pend_q, hwlp_pend_q, hwlp_inflight_q;

  logic        resp_done, push, can_issue, issue_cond, issue, sel_hwlp;
  logic [31:0] next_fetch, issue_addr;

  assign resp_done  = ((state == WAIT_RVALID) || (state == WAIT_ABORTED)) && instr_rvalid_i;
  assign push       = (state == WAIT_RVALID) && instr_rvalid_i && !branch_i;
  assign can_issue  = (state == IDLE) || resp_done;
  assign issue_cond = (req_i && fifo_ready_i) || branch_i;
  assign issue      = can_issue && issue_cond && !rst;
  assign sel_hwlp   = !branch_i && !tgt_pend_q && hwlp_pend_q;

  // Issuing in the rvalid cycle must already see the address after the word being pushed.
  assign next_fetch = push ? (hwlp_inflight_q ? hwlp_q + 32'd4
                                              : {req_addr_q[31:2], 2'b00} + 32'd4)
                           : fetch_addr_q;

  always_comb begin
    issue_addr = next_fetch;
    if (branch_i)         issue_addr = branch_addr_i;
    else if (tgt_pend_q)  issue_addr = tgt_q;
    else if (hwlp_pend_q) issue_addr = hwlp_q;
  end

  always_comb begin
    state_next   = state;
    instr_req_o  = 1'b0;
    instr_addr_o = 32'd0;
    case (state)
      WAIT_GNT: begin
        instr_req_o  = 1'b1;
        instr_addr_o = {req_addr_q[31:2], 2'b00};
        if (instr_gnt_i)
          state_next = (tgt_pend_q || branch_i) ? WAIT_ABORTED : WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (instr_rvalid_i) state_next = IDLE;
        else if (branch_i)  state_next = WAIT_ABORTED;
      end
      WAIT_ABORTED: begin
        if (instr_rvalid_i) state_next = IDLE;
      end
      default: state_next = state;
    endcase
    if (issue) begin
      instr_req_o  = 1'b1;
      instr_addr_o = {issue_addr[31:2], 2'b00};
      state_next   = instr_gnt_i ? WAIT_RVALID : WAIT_GNT;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      fetch_addr_q    <= 32'd0;
      req_addr_q      <= 32'd0;
      tgt_q           <= 32'd0;
      hwlp_q          <= 32'd0;
      tgt_pend_q      <= 1'b0;
      hwlp_pend_q     <= 1'b0;
      hwlp_inflight_q <= 1'b0;
    end else begin
      state <= state_next;
      if (push) fetch_addr_q <= next_fetch;
      // req_addr_q keeps the unaligned branch target so the FIFO sees the halfword offset.
      if (issue) begin
        req_addr_q      <= issue_addr;
        hwlp_inflight_q <= sel_hwlp;
        tgt_pend_q      <= 1'b0;
      end else if (resp_done) begin
        hwlp_inflight_q <= 1'b0;
      end
      if (branch_i && !issue) begin
        tgt_q      <= branch_addr_i;
        tgt_pend_q <= 1'b1;
      end
      if (hwlp_branch_i) begin
        hwlp_pend_q <= 1'b1;
        hwlp_q      <= hwlp_target_i;
      end else if (instr_gnt_i && (issue ? sel_hwlp : ((state == WAIT_GNT) && hwlp_inflight_q))) begin
        hwlp_pend_q <= 1'b0;
      end
      if (branch_i) begin
        hwlp_pend_q     <= 1'b0;
        hwlp_inflight_q <= 1'b0;
      end
    end
  end

  assign fifo_clear_o    = branch_i;
  assign fifo_valid_o    = push;
  assign fifo_addr_o     = push ? req_addr_q : 32'd0;
  assign fifo_rdata_o    = instr_rdata_i;
  assign fifo_replace2_o = push && hwlp_inflight_q;
  assign fifo_is_hwlp_o  = push && hwlp_inflight_q;
  assign busy_o          = (state != IDLE);

endmodule

// File: tb/tb_riscv_nn_prefetch_ctrl.sv
// tb/tb_riscv_nn_prefetch_ctrl.sv - directed bench for riscv_nn_prefetch_ctrl
// Memory side grants combinationally and returns one response per grant when enabled.
module tb_riscv_nn_prefetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_i = 1'b0, branch_i = 1'b0, hwlp_branch_i = 1'b0, fifo_ready_i = 1'b1;
  logic [31:0] branch_addr_i = 32'd0, hwlp_target_i = 32'd0;
  logic        instr_req_o, instr_gnt_i, instr_rvalid_i;
  logic [31:0] instr_addr_o, instr_rdata_i;
  logic        fifo_clear_o, fifo_valid_o, fifo_replace2_o, fifo_is_hwlp_o, busy_o;
  logic [31:0] fifo_addr_o, fifo_rdata_o;

  logic        gnt_en = 1'b1, rv_en = 1'b1, outstanding;
  logic [31:0] mem_addr;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  riscv_nn_prefetch_ctrl dut (
    .clk(clk), .rst(rst), .req_i(req_i), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .hwlp_branch_i(hwlp_branch_i), .hwlp_target_i(hwlp_target_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .fifo_clear_o(fifo_clear_o), .fifo_valid_o(fifo_valid_o), .fifo_addr_o(fifo_addr_o),
    .fifo_rdata_o(fifo_rdata_o), .fifo_ready_i(fifo_ready_i),
    .fifo_replace2_o(fifo_replace2_o), .fifo_is_hwlp_o(fifo_is_hwlp_o), .busy_o(busy_o)
  );

  assign instr_gnt_i    = instr_req_o && gnt_en;
  assign instr_rvalid_i = outstanding && rv_en;
  assign instr_rdata_i  = ~mem_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= 1'b0;
      mem_addr    <= 32'd0;
    end else begin
      outstanding <= (instr_req_o && instr_gnt_i) || (outstanding && !instr_rvalid_i);
      if (instr_req_o && instr_gnt_i) mem_addr <= instr_addr_o;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_chk(input string tag, input logic [31:0] a, input logic hw);
    chk({tag, "_valid"}, {31'd0, fifo_valid_o}, 32'd1);
    chk({tag, "_addr"}, fifo_addr_o, a);
    chk({tag, "_repl2"}, {31'd0, fifo_replace2_o}, {31'd0, hw});
    chk({tag, "_hwlp"}, {31'd0, fifo_is_hwlp_o}, {31'd0, hw});
  endtask

  task automatic req_chk(input string tag, input logic rq, input logic [31:0] a);
    chk({tag, "_req"}, {31'd0, instr_req_o}, {31'd0, rq});
    if (rq) chk({tag, "_raddr"}, instr_addr_o, a);
  endtask

  initial begin
    #2 rst = 1'b1;
    @(negedge clk); #1;
    chk("rst_req", {31'd0, instr_req_o}, 32'd0);
    chk("rst_addr", instr_addr_o, 32'd0);
    chk("rst_valid", {31'd0, fifo_valid_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_repl2", {31'd0, fifo_replace2_o}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // sequential fetch from 0x100, hwlp to 0x400 while 0x10C is in flight
    @(negedge clk); req_i = 1; branch_i = 1; branch_addr_i = 32'h100; #1;
    chk("seq_clear", {31'd0, fifo_clear_o}, 32'd1);
    req_chk("seq0", 1, 32'h100);
    @(negedge clk); branch_i = 0; #1;
    push_chk("seq_p100", 32'h100, 0);
    chk("seq_rdata", fifo_rdata_o, 32'hFFFF_FEFF);
    req_chk("seq1", 1, 32'h104);
    @(negedge clk); #1;
    push_chk("seq_p104", 32'h104, 0);
    req_chk("seq2", 1, 32'h108);
    @(negedge clk); hwlp_branch_i = 1; hwlp_target_i = 32'h400; #1;
    push_chk("seq_p108", 32'h108, 0);
    req_chk("seq3", 1, 32'h10C);
    @(negedge clk); hwlp_branch_i = 0; #1;
    push_chk("hw_p10c", 32'h10C, 0);
    req_chk("hw_req400", 1, 32'h400);
    @(negedge clk); #1;
    push_chk("hw_p400", 32'h400, 1);
    req_chk("hw_req404", 1, 32'h404);
    @(negedge clk); req_i = 0; #1;
    push_chk("hw_p404", 32'h404, 0);
    req_chk("hw_stop", 0, 32'h0);
    @(negedge clk); #1;
    chk("hw_idle_busy", {31'd0, busy_o}, 32'd0);

    // grant stall at 0x200
    @(negedge clk); gnt_en = 0; branch_i = 1; branch_addr_i = 32'h200; #1;
    req_chk("gs0", 1, 32'h200);
    @(negedge clk); branch_i = 0; #1;
    req_chk("gs1", 1, 32'h200);
    chk("gs1_busy", {31'd0, busy_o}, 32'd1);
    @(negedge clk); #1;
    req_chk("gs2", 1, 32'h200);
    @(negedge clk); #1;
    req_chk("gs3", 1, 32'h200);
    chk("gs3_valid", {31'd0, fifo_valid_o}, 32'd0);
    @(negedge clk); gnt_en = 1; #1;
    req_chk("gs4", 1, 32'h200);
    @(negedge clk); #1;
    push_chk("gs_p200", 32'h200, 0);
    req_chk("gs_stop", 0, 32'h0);

    // branch in WAIT_RVALID to 0x302, then branch coinciding with rvalid
    @(negedge clk); req_i = 1; branch_i = 1; branch_addr_i = 32'h500; #1;
    req_chk("ab0", 1, 32'h500);
    @(negedge clk); rv_en = 0; branch_addr_i = 32'h302; #1;
    chk("ab_clear", {31'd0, fifo_clear_o}, 32'd1);
    chk("ab_novalid", {31'd0, fifo_valid_o}, 32'd0);
    req_chk("ab1", 0, 32'h0);
    @(negedge clk); branch_i = 0; rv_en = 1; #1;
    chk("ab_discard", {31'd0, fifo_valid_o}, 32'd0);
    req_chk("ab_req300", 1, 32'h300);
    @(negedge clk); #1;
    push_chk("ab_p302", 32'h302, 0);
    req_chk("ab_req304", 1, 32'h304);
    @(negedge clk); #1;
    push_chk("ab_p304", 32'h304, 0);
    req_chk("ab_req308", 1, 32'h308);
    @(negedge clk); branch_i = 1; branch_addr_i = 32'h600; #1;
    chk("sb_novalid", {31'd0, fifo_valid_o}, 32'd0);
    req_chk("sb_req600", 1, 32'h600);
    @(negedge clk); branch_i = 0; req_i = 0; #1;
    push_chk("sb_p600", 32'h600, 0);
    req_chk("sb_stop", 0, 32'h0);

    // backpressure
    @(negedge clk); req_i = 1; branch_i = 1; branch_addr_i = 32'h700; #1;
    req_chk("bp0", 1, 32'h700);
    @(negedge clk); branch_i = 0; fifo_ready_i = 0; #1;
    push_chk("bp_p700", 32'h700, 0);
    req_chk("bp_hold", 0, 32'h0);
    @(negedge clk); #1;
    chk("bp_busy", {31'd0, busy_o}, 32'd0);
    req_chk("bp_idle", 0, 32'h0);
    @(negedge clk); fifo_ready_i = 1; #1;
    req_chk("bp_resume", 1, 32'h704);
    @(negedge clk); req_i = 0; #1;
    push_chk("bp_p704", 32'h704, 0);

    // address wrap
    @(negedge clk); req_i = 1; branch_i = 1; branch_addr_i = 32'hFFFF_FFFC; #1;
    req_chk("wr0", 1, 32'hFFFF_FFFC);
    @(negedge clk); branch_i = 0; #1;
    push_chk("wr_pfffc", 32'hFFFF_FFFC, 0);
    req_chk("wr_req0", 1, 32'h0);
    @(negedge clk); req_i = 0; #1;
    push_chk("wr_p0", 32'h0, 0);

    // reset mid-fetch
    @(negedge clk); req_i = 1; branch_i = 1; branch_addr_i = 32'h800; #1;
    req_chk("mr0", 1, 32'h800);
    @(negedge clk); branch_i = 0; rv_en = 0; #1;
    chk("mr_busy_pre", {31'd0, busy_o}, 32'd1);
    rst = 1; #1;
    chk("mr_req", {31'd0, instr_req_o}, 32'd0);
    chk("mr_addr", instr_addr_o, 32'd0);
    chk("mr_busy", {31'd0, busy_o}, 32'd0);
    chk("mr_valid", {31'd0, fifo_valid_o}, 32'd0);
    @(negedge clk); rst = 0; req_i = 0; rv_en = 1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
